// File: rtl/cfg_pkg.sv
// Build-time defaults for the update arbiter.
package cfg_pkg;
  localparam int REQ_N_DEF  = 4;
  localparam int FIFO_D_DEF = 2;
endpackage

// File: rtl/v_pkg.sv
// Shared types for the list-update path: payload fields, request struct, arbiter state.
package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [3:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [11:0] size_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } arb_state_t;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_req_t;
endpackage

// File: rtl/v_upd_arb_fifo.sv
// Two-entry per-requester update buffer; ready and empty come straight from registered occupancy.
module v_upd_arb_fifo
  import v_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  upd_req_t din,
  output upd_req_t dout,
  output logic     rdy,
  output logic     empty
);

  upd_req_t   mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] cnt_r;

  // Storage, wrapping 1-bit pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign rdy   = (cnt_r != 2'(DEPTH));
  assign empty = (cnt_r == 2'd0);

endmodule

// File: rtl/v_upd_arb.sv
// Round-robin arbiter merging per-requester update FIFOs onto the list-engine update bus.
// Optional V_UPD_ARB_CNT_EN adds saturating per-requester grant counters (o_grant_cnt_r).
module v_upd_arb
  import v_pkg::*;
#(
  parameter int REQ_N  = cfg_pkg::REQ_N_DEF,
  parameter int FIFO_D = cfg_pkg::FIFO_D_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_N-1:0]           i_req_vld,
  output logic [REQ_N-1:0]           o_req_rdy,
  input  id_t  [REQ_N-1:0]           i_req_prod_id,
  input  cmd_t [REQ_N-1:0]           i_req_cmd,
  input  key_t [REQ_N-1:0]           i_req_key,
  input  size_t [REQ_N-1:0]          i_req_size,
  input  logic                       i_busy,
  output logic                       o_upd_vld_r,
  output id_t                        o_upd_prod_id_r,
  output cmd_t                       o_upd_cmd_r,
  output key_t                       o_upd_key_r,
  output size_t                      o_upd_size_r,
  output logic [$clog2(REQ_N)-1:0]   o_upd_src_r,
`ifdef V_UPD_ARB_CNT_EN
  output logic [REQ_N-1:0][15:0]     o_grant_cnt_r,
`endif
  output logic                       o_run_r
);

  localparam int SRC_W = $clog2(REQ_N);

  arb_state_t             state_r;
  logic [SRC_W-1:0]       last_grant_r;
  logic [SRC_W-1:0]       gnt_idx_s;
  logic                   gnt_vld_s;
  logic [REQ_N-1:0]       push_s;
  logic [REQ_N-1:0]       pop_s;
  logic [REQ_N-1:0]       empty_s;
  upd_req_t [REQ_N-1:0]   head_s;
  upd_req_t               gnt_req_s;

  // First requester above the last grant wins; otherwise wrap to the lowest index.
  function automatic logic [SRC_W:0] rr_pick(input logic [REQ_N-1:0] req,
                                             input logic [SRC_W-1:0] last);
    logic             hi_found;
    logic             lo_found;
    logic [SRC_W-1:0] hi_idx;
    logic [SRC_W-1:0] lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SRC_W'(i);
      end
      if (req[i] && !hi_found && (SRC_W'(i) > last)) begin
        hi_found = 1'b1;
        hi_idx   = SRC_W'(i);
      end
    end
    return hi_found ? {1'b1, hi_idx} : {lo_found, lo_idx};
  endfunction

  genvar g;
  generate
    for (g = 0; g < REQ_N; g++) begin : g_fifo
      upd_req_t din_s;
      assign din_s     = {i_req_prod_id[g], i_req_cmd[g], i_req_key[g], i_req_size[g]};
      assign push_s[g] = i_req_vld[g] & o_req_rdy[g];

      v_upd_arb_fifo #(.DEPTH(FIFO_D)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s[g]),
        .pop   (pop_s[g]),
        .din   (din_s),
        .dout  (head_s[g]),
        .rdy   (o_req_rdy[g]),
        .empty (empty_s[g])
      );
    end
  endgenerate

  // Grant selection; busy blocks new grants even before the state leaves RUN.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    if ((state_r == ST_RUN) && !i_busy) begin
      {gnt_vld_s, gnt_idx_s} = rr_pick(~empty_s, last_grant_r);
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  // Pop the granted head in the same cycle it is registered on the bus.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < REQ_N; i++) begin
      pop_s[i] = gnt_vld_s && (gnt_idx_s == SRC_W'(i));
    end
  end

  assign gnt_req_s = head_s[gnt_idx_s];

  // Arbiter FSM with registered run flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_BOOT;
      o_run_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          if (i_busy) begin
            state_r <= ST_INIT;
          end else begin
            state_r <= ST_BOOT;
          end
          o_run_r <= 1'b0;
        end
        ST_INIT: begin
          if (!i_busy) begin
            state_r <= ST_RUN;
            o_run_r <= 1'b1;
          end else begin
            state_r <= ST_INIT;
            o_run_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_busy) begin
            state_r <= ST_INIT;
            o_run_r <= 1'b0;
          end else begin
            state_r <= ST_RUN;
            o_run_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_BOOT;
          o_run_r <= 1'b0;
        end
      endcase
    end
  end

  // Update bus registers; payload holds between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r    <= SRC_W'(REQ_N - 1);
      o_upd_vld_r     <= 1'b0;
      o_upd_prod_id_r <= '0;
      o_upd_cmd_r     <= '0;
      o_upd_key_r     <= '0;
      o_upd_size_r    <= '0;
      o_upd_src_r     <= '0;
    end else begin
      o_upd_vld_r <= gnt_vld_s;
      if (gnt_vld_s) begin
        last_grant_r    <= gnt_idx_s;
        o_upd_prod_id_r <= gnt_req_s.prod_id;
        o_upd_cmd_r     <= gnt_req_s.cmd;
        o_upd_key_r     <= gnt_req_s.key;
        o_upd_size_r    <= gnt_req_s.size;
        o_upd_src_r     <= gnt_idx_s;
      end
    end
  end

`ifdef V_UPD_ARB_CNT_EN
  // Saturating grant counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_grant_cnt_r <= '0;
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        if (pop_s[i] && (o_grant_cnt_r[i] != 16'hFFFF)) begin
          o_grant_cnt_r[i] <= o_grant_cnt_r[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_v_upd_arb.sv
// Directed self-checking bench for v_upd_arb (REQ_N = 4).
module tb_v_upd_arb;
  import v_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_req_vld;
  logic [3:0]  o_req_rdy;
  id_t  [3:0]  i_req_prod_id;
  cmd_t [3:0]  i_req_cmd;
  key_t [3:0]  i_req_key;
  size_t [3:0] i_req_size;
  logic        i_busy;
  logic        o_upd_vld_r;
  id_t         o_upd_prod_id_r;
  cmd_t        o_upd_cmd_r;
  key_t        o_upd_key_r;
  size_t       o_upd_size_r;
  logic [1:0]  o_upd_src_r;
  logic        o_run_r;
`ifdef V_UPD_ARB_CNT_EN
  logic [3:0][15:0] o_grant_cnt_r;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  int         push_cnt [4];
  int         out_cnt  [4];
  logic [3:0] stream_en;

  always #5 clk = ~clk;

  v_upd_arb #(.REQ_N(4), .FIFO_D(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_vld       (i_req_vld),
    .o_req_rdy       (o_req_rdy),
    .i_req_prod_id   (i_req_prod_id),
    .i_req_cmd       (i_req_cmd),
    .i_req_key       (i_req_key),
    .i_req_size      (i_req_size),
    .i_busy          (i_busy),
    .o_upd_vld_r     (o_upd_vld_r),
    .o_upd_prod_id_r (o_upd_prod_id_r),
    .o_upd_cmd_r     (o_upd_cmd_r),
    .o_upd_key_r     (o_upd_key_r),
    .o_upd_size_r    (o_upd_size_r),
    .o_upd_src_r     (o_upd_src_r),
`ifdef V_UPD_ARB_CNT_EN
    .o_grant_cnt_r   (o_grant_cnt_r),
`endif
    .o_run_r         (o_run_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stream();
    for (int i = 0; i < 4; i++) begin
      i_req_vld[i]     = stream_en[i];
      i_req_key[i]     = key_t'(i * 256 + push_cnt[i]);
      i_req_prod_id[i] = id_t'(i);
    end
  endtask

  task automatic stream_cycle();
    logic [3:0] acc;
    acc = i_req_vld & o_req_rdy;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) push_cnt[i]++;
    end
    load_stream();
  endtask

  task automatic bringup();
    rst = 1'b0; i_busy = 1'b0; i_req_vld = '0; stream_en = '0;
    for (int i = 0; i < 4; i++) begin push_cnt[i] = 0; out_cnt[i] = 0; end
    tick();
    rst = 1'b1; i_busy = 1'b1;
    tick(); tick();
    i_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0b want 0", o_upd_vld_r); end
    n_vec++; if (o_req_rdy !== 4'hF) begin n_err++; $display("FAIL reset_rdy: got %0h want f", o_req_rdy); end
    n_vec++; if (o_run_r !== 1'b0) begin n_err++; $display("FAIL reset_run: got %0b want 0", o_run_r); end
    n_vec++; if (o_upd_key_r !== 16'h0000) begin n_err++; $display("FAIL reset_key: got %0h want 0", o_upd_key_r); end
    n_vec++; if (o_upd_src_r !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", o_upd_src_r); end
  endtask

  task automatic test_boot_seq();
    logic exp_rdy;
    rst = 1'b1; i_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (o_run_r !== 1'b0) begin n_err++; $display("FAIL boot_idle_run: got %0b want 0", o_run_r); end
    end
    i_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++;
      if (o_run_r !== 1'b0 || o_upd_vld_r !== 1'b0) begin
        n_err++; $display("FAIL init_quiet: got run=%0b vld=%0b want 0/0", o_run_r, o_upd_vld_r);
      end
      if (k >= 2) begin
        exp_rdy = (k == 2);
        n_vec++; if (o_req_rdy[2] !== exp_rdy) begin n_err++; $display("FAIL init_rdy2 k=%0d: got %0b want %0b", k, o_req_rdy[2], exp_rdy); end
      end
      if (k == 1) begin i_req_vld[2] = 1'b1; i_req_key[2] = 16'h0021; end
      else if (k == 2) i_req_key[2] = 16'h0022;
      else if (k == 3) i_req_key[2] = 16'h0023;
    end
    i_busy = 1'b0;
    tick();
    n_vec++; if (o_run_r !== 1'b1) begin n_err++; $display("FAIL run_rise: got %0b want 1", o_run_r); end
    n_vec++; if (o_upd_vld_r !== 1'b0 || o_req_rdy[2] !== 1'b0) begin n_err++; $display("FAIL run_first: got vld=%0b rdy2=%0b want 0/0", o_upd_vld_r, o_req_rdy[2]); end
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b1 || o_upd_key_r !== 16'h0021 || o_upd_src_r !== 2'd2) begin n_err++; $display("FAIL drain1: got vld=%0b key=%0h src=%0d want 1/21/2", o_upd_vld_r, o_upd_key_r, o_upd_src_r); end
    n_vec++; if (o_req_rdy[2] !== 1'b1) begin n_err++; $display("FAIL drain1_rdy2: got %0b want 1", o_req_rdy[2]); end
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b1 || o_upd_key_r !== 16'h0022) begin n_err++; $display("FAIL drain2: got vld=%0b key=%0h want 1/22", o_upd_vld_r, o_upd_key_r); end
    i_req_vld[2] = 1'b0;
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b1 || o_upd_key_r !== 16'h0023) begin n_err++; $display("FAIL drain3: got vld=%0b key=%0h want 1/23", o_upd_vld_r, o_upd_key_r); end
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b0) begin n_err++; $display("FAIL drain_end: got %0b want 0", o_upd_vld_r); end
  endtask

  task automatic test_single();
    n_vec++; if (o_req_rdy[0] !== 1'b1) begin n_err++; $display("FAIL single_rdy_pre: got %0b want 1", o_req_rdy[0]); end
    i_req_vld[0] = 1'b1; i_req_key[0] = 16'h0011;
    tick();
    i_req_vld[0] = 1'b0;
    n_vec++; if (o_upd_vld_r !== 1'b0 || o_req_rdy[0] !== 1'b1) begin n_err++; $display("FAIL single_t1: got vld=%0b rdy0=%0b want 0/1", o_upd_vld_r, o_req_rdy[0]); end
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b1 || o_upd_key_r !== 16'h0011 || o_upd_src_r !== 2'd0) begin n_err++; $display("FAIL single_t2: got vld=%0b key=%0h src=%0d want 1/11/0", o_upd_vld_r, o_upd_key_r, o_upd_src_r); end
    n_vec++; if (o_req_rdy[0] !== 1'b1) begin n_err++; $display("FAIL single_rdy_t2: got %0b want 1", o_req_rdy[0]); end
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b0 || o_upd_key_r !== 16'h0011) begin n_err++; $display("FAIL single_hold: got vld=%0b key=%0h want 0/11", o_upd_vld_r, o_upd_key_r); end
  endtask

  task automatic test_back_to_back();
    int   exp_src;
    key_t exp_key;
    bringup();
    stream_en = 4'hF; load_stream();
    exp_src = 0;
    for (int c = 0; c < 24; c++) begin
      stream_cycle();
      n_vec++;
      if (c == 0) begin
        if (o_upd_vld_r !== 1'b0) begin n_err++; $display("FAIL b2b_first: got %0b want 0", o_upd_vld_r); end
      end else begin
        exp_key = key_t'(exp_src * 256 + out_cnt[exp_src]);
        if (o_upd_vld_r !== 1'b1 || o_upd_src_r !== 2'(exp_src) || o_upd_key_r !== exp_key || o_upd_prod_id_r !== id_t'(exp_src)) begin
          n_err++; $display("FAIL b2b c=%0d: got vld=%0b src=%0d key=%0h want 1/%0d/%0h", c, o_upd_vld_r, o_upd_src_r, o_upd_key_r, exp_src, exp_key);
        end
        out_cnt[exp_src]++;
        exp_src = (exp_src + 1) % 4;
      end
    end
    stream_en = 4'h0; load_stream();
    for (int c = 0; c < 16; c++) begin
      stream_cycle();
      if (o_upd_vld_r === 1'b1) begin
        exp_key = key_t'(int'(o_upd_src_r) * 256 + out_cnt[o_upd_src_r]);
        n_vec++; if (o_upd_key_r !== exp_key) begin n_err++; $display("FAIL b2b_drain: got %0h want %0h", o_upd_key_r, exp_key); end
        out_cnt[o_upd_src_r]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_cnt[i] !== push_cnt[i]) begin n_err++; $display("FAIL b2b_count%0d: got %0d want %0d", i, out_cnt[i], push_cnt[i]); end
    end
  endtask

  task automatic test_busy_pulse();
    int   busy_hits;
    key_t exp_key;
    bringup();
    busy_hits = 0;
    stream_en = 4'b0011; load_stream();
    for (int c = 0; c < 30; c++) begin
      if (c == 8) i_busy = 1'b1;
      if (c == 12) i_busy = 1'b0;
      if (c == 20) begin stream_en = 4'b0000; load_stream(); end
      stream_cycle();
      if (c >= 8 && c < 12 && o_upd_vld_r === 1'b1) busy_hits++;
      if (c == 9) begin
        n_vec++; if (o_run_r !== 1'b0) begin n_err++; $display("FAIL busy_run: got %0b want 0", o_run_r); end
      end
      if (c == 12) begin
        n_vec++; if (o_upd_vld_r !== 1'b0 || o_run_r !== 1'b1) begin n_err++; $display("FAIL busy_resume: got vld=%0b run=%0b want 0/1", o_upd_vld_r, o_run_r); end
      end
      if (o_upd_vld_r === 1'b1) begin
        exp_key = key_t'(int'(o_upd_src_r) * 256 + out_cnt[o_upd_src_r]);
        n_vec++; if (o_upd_key_r !== exp_key) begin n_err++; $display("FAIL busy_order: got %0h want %0h", o_upd_key_r, exp_key); end
        out_cnt[o_upd_src_r]++;
      end
    end
    n_vec++; if (busy_hits > 1) begin n_err++; $display("FAIL busy_hits: got %0d want <=1", busy_hits); end
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (out_cnt[i] !== push_cnt[i]) begin n_err++; $display("FAIL busy_count%0d: got %0d want %0d", i, out_cnt[i], push_cnt[i]); end
    end
`ifdef V_UPD_ARB_CNT_EN
    n_vec++; if (o_grant_cnt_r[0] !== 16'(out_cnt[0])) begin n_err++; $display("FAIL grant_cnt0: got %0d want %0d", o_grant_cnt_r[0], out_cnt[0]); end
`endif
  endtask

  task automatic test_reset_full();
    i_busy = 1'b1;
    tick();
    stream_en = 4'b0011; load_stream();
    for (int c = 0; c < 3; c++) stream_cycle();
    n_vec++; if (o_req_rdy !== 4'b1100) begin n_err++; $display("FAIL full_rdy: got %0h want c", o_req_rdy); end
    stream_en = 4'b0000; load_stream();
    rst = 1'b0;
    tick();
    n_vec++; if (o_upd_vld_r !== 1'b0 || o_req_rdy !== 4'hF || o_run_r !== 1'b0) begin n_err++; $display("FAIL rst_full: got vld=%0b rdy=%0h run=%0b want 0/f/0", o_upd_vld_r, o_req_rdy, o_run_r); end
    n_vec++; if (o_upd_key_r !== 16'h0000 || o_upd_src_r !== 2'd0) begin n_err++; $display("FAIL rst_payload: got key=%0h src=%0d want 0/0", o_upd_key_r, o_upd_src_r); end
`ifdef V_UPD_ARB_CNT_EN
    n_vec++; if (o_grant_cnt_r !== '0) begin n_err++; $display("FAIL rst_cnt: got %0h want 0", o_grant_cnt_r); end
`endif
    rst = 1'b1; i_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++; if (o_upd_vld_r !== 1'b0 || o_run_r !== 1'b0) begin n_err++; $display("FAIL post_rst c=%0d: got vld=%0b run=%0b want 0/0", c, o_upd_vld_r, o_run_r); end
    end
  endtask

  initial begin
    i_req_vld = '0; i_req_prod_id = '0; i_req_cmd = '0; i_req_key = '0; i_req_size = '0;
    i_busy = 1'b0; stream_en = '0;
    for (int i = 0; i < 4; i++) begin push_cnt[i] = 0; out_cnt[i] = 0; end
    test_reset();
    test_boot_seq();
    test_single();
    test_back_to_back();
    test_busy_pulse();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
